// File: rtl/rf_pkg.sv
// Shared register-file constants so decode, fetch and the register file agree on PC index and offsets.
// Optional write-to-read forwarding is enabled with the RF_BYPASS_EN macro (see rf_read_port).
package rf_pkg;

  localparam int RF_DATA_W      = 32;
  localparam int RF_ADDR_W      = 4;
  localparam int RF_NUM_REGS    = 2 ** RF_ADDR_W;
  localparam int RF_PC_IDX      = 15;
  localparam int RF_PC_STEP     = 4;
  localparam int RF_PC_READ_OFS = 8;

  localparam logic [RF_DATA_W-1:0] RF_RESET_PC = 32'h0000_0000;

  typedef logic [RF_DATA_W-1:0] rf_word_t;
  typedef logic [RF_ADDR_W-1:0] rf_idx_t;

endpackage

// File: rtl/param_register_file_if.sv
// Register-file bus: decode-side indices and write data in, operands and fetch PC out.
// Signal names follow the processor's legacy register-file pinout.
interface param_register_file_if #(
  parameter int DATA_W = rf_pkg::RF_DATA_W,
  parameter int ADDR_W = rf_pkg::RF_ADDR_W
);

  logic [DATA_W-1:0] I;
  logic [ADDR_W-1:0] Rc;
  logic              LE;
  logic [ADDR_W-1:0] Ra;
  logic [ADDR_W-1:0] Rb;
  logic [ADDR_W-1:0] Rd;
  logic              PC_INC;
  logic [DATA_W-1:0] Y0;
  logic [DATA_W-1:0] Y1;
  logic [DATA_W-1:0] Y2;
  logic [DATA_W-1:0] PC;

  modport master (
    output I, Rc, LE, Ra, Rb, Rd, PC_INC,
    input  Y0, Y1, Y2, PC
  );

  modport slave (
    input  I, Rc, LE, Ra, Rb, Rd, PC_INC,
    output Y0, Y1, Y2, PC
  );

endinterface

// File: rtl/rf_read_port.sv
// One combinational read port: index mux, PC read offset and, with RF_BYPASS_EN defined,
// same-cycle forwarding of the pending write data.
module rf_read_port #(
  parameter int                DATA_W      = rf_pkg::RF_DATA_W,
  parameter int                ADDR_W      = rf_pkg::RF_ADDR_W,
  parameter int                PC_IDX      = rf_pkg::RF_PC_IDX,
  parameter logic [DATA_W-1:0] PC_READ_OFS = DATA_W'(rf_pkg::RF_PC_READ_OFS)
) (
  input  logic [(2**ADDR_W)-1:0][DATA_W-1:0] regs,
  input  logic [ADDR_W-1:0]                  idx,
  input  logic                               wr_en,
  input  logic [ADDR_W-1:0]                  wr_idx,
  input  logic [DATA_W-1:0]                  wr_data,
  output logic [DATA_W-1:0]                  data
);

  localparam logic [ADDR_W-1:0] PC_SEL = ADDR_W'(PC_IDX);

  logic [DATA_W-1:0] stored;

`ifndef RF_BYPASS_EN
  logic unused_bypass;
  assign unused_bypass = ^{wr_en, wr_idx, wr_data};
`endif

  // NOTE: every variable driven here gets a default first, so no path leaves it unassigned
  // and no latch is inferred.
  always_comb begin
    stored = regs[idx];
`ifdef RF_BYPASS_EN
    if (wr_en && (idx == wr_idx)) stored = wr_data;
`endif
    data = (idx == PC_SEL) ? stored + PC_READ_OFS : stored;
  end

endmodule

// File: rtl/param_register_file.sv
// NUM_REGS x DATA_W register file with three combinational read ports, one write port and a
// self-incrementing PC register. Define RF_BYPASS_EN for same-cycle write-to-read forwarding.
module param_register_file
  import rf_pkg::*;
#(
  parameter int                DATA_W      = RF_DATA_W,
  parameter int                ADDR_W      = RF_ADDR_W,
  parameter int                PC_IDX      = RF_PC_IDX,
  parameter logic [DATA_W-1:0] RESET_PC    = DATA_W'(RF_RESET_PC),
  parameter logic [DATA_W-1:0] PC_STEP     = DATA_W'(RF_PC_STEP),
  parameter logic [DATA_W-1:0] PC_READ_OFS = DATA_W'(RF_PC_READ_OFS)
) (
  input  logic                 clk,
  input  logic                 clr,
  param_register_file_if.slave bus
);

  localparam int                NUM_REGS = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] PC_SEL   = ADDR_W'(PC_IDX);

  logic [NUM_REGS-1:0][DATA_W-1:0] regs;
  logic                            wr_en;
  logic                            pc_wr;

  assign wr_en = ~bus.LE;
  assign pc_wr = wr_en && (bus.Rc == PC_SEL);

  // NOTE: the whole array sits on the async reset because software relies on every register
  // reading 0 (and the PC reading RESET_PC) after clr; this forces flops rather than RAM.
  // NOTE: sequential state uses non-blocking assignments only, so all flops update together.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      regs         <= '0;
      regs[PC_SEL] <= RESET_PC;
    end else begin
      if (wr_en) regs[bus.Rc] <= bus.I;
      // A branch/load of the PC overrides the sequential fetch increment.
      if (!pc_wr && bus.PC_INC) regs[PC_SEL] <= regs[PC_SEL] + PC_STEP;
    end
  end

  assign bus.PC = regs[PC_SEL];

  rf_read_port #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .PC_IDX(PC_IDX), .PC_READ_OFS(PC_READ_OFS)
  ) u_rd0 (
    .regs(regs), .idx(bus.Ra), .wr_en(wr_en), .wr_idx(bus.Rc), .wr_data(bus.I), .data(bus.Y0)
  );

  rf_read_port #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .PC_IDX(PC_IDX), .PC_READ_OFS(PC_READ_OFS)
  ) u_rd1 (
    .regs(regs), .idx(bus.Rb), .wr_en(wr_en), .wr_idx(bus.Rc), .wr_data(bus.I), .data(bus.Y1)
  );

  rf_read_port #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .PC_IDX(PC_IDX), .PC_READ_OFS(PC_READ_OFS)
  ) u_rd2 (
    .regs(regs), .idx(bus.Rd), .wr_en(wr_en), .wr_idx(bus.Rc), .wr_data(bus.I), .data(bus.Y2)
  );

endmodule

// File: tb/tb_param_register_file.sv
// Scoreboard bench for param_register_file: stimulus queues hand-computed expectations,
// a monitor process pops and compares them whenever a sample point is signalled.
module tb_param_register_file;

  typedef enum int { P_Y0, P_Y1, P_Y2, P_PC } port_e;

  typedef struct {
    string       name;
    port_e       port;
    logic [31:0] value;
  } exp_t;

  logic clk = 1'b0;
  logic clr = 1'b0;
  int   tests_run = 0;
  int   tests_failed = 0;
  exp_t exp_q[$];
  event sample_ev;

  param_register_file_if #(.DATA_W(32), .ADDR_W(4)) bus ();

  param_register_file dut (
    .clk(clk),
    .clr(clr),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: drains every queued expectation at each sample point.
  initial begin
    exp_t        e;
    logic [31:0] act;
    forever begin
      @(sample_ev);
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        case (e.port)
          P_Y0:    act = bus.Y0;
          P_Y1:    act = bus.Y1;
          P_Y2:    act = bus.Y2;
          default: act = bus.PC;
        endcase
        check(e.name, act, e.value);
      end
    end
  end

  task automatic expect_out(input string name, input port_e port, input logic [31:0] value);
    exp_t e;
    e.name  = name;
    e.port  = port;
    e.value = value;
    exp_q.push_back(e);
  endtask

  // Let combinational reads settle, then hand the queue to the monitor.
  task automatic sample();
    #1;
    -> sample_ev;
    #1;
  endtask

  // Advance one rising edge; inputs are changed 2 time units after it.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_reads(input logic [3:0] a, input logic [3:0] b, input logic [3:0] d);
    bus.Ra = a;
    bus.Rb = b;
    bus.Rd = d;
  endtask

  task automatic write(input logic [3:0] idx, input logic [31:0] data);
    bus.LE = 1'b0;
    bus.Rc = idx;
    bus.I  = data;
    tick();
    bus.LE = 1'b1;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.I = '0; bus.Rc = '0; bus.LE = 1'b1; bus.PC_INC = 1'b0;
    set_reads(4'd0, 4'd15, 4'd7);

    // Reset held, then released between edges.
    #12;
    expect_out("rst_y0_r0", P_Y0, 32'h0);
    expect_out("rst_y1_pc", P_Y1, 32'h8);
    expect_out("rst_y2_r7", P_Y2, 32'h0);
    expect_out("rst_pc", P_PC, 32'h0);
    sample();
    clr = 1'b1;
    expect_out("rel_y1_pc", P_Y1, 32'h8);
    expect_out("rel_pc", P_PC, 32'h0);
    sample();

    // Single write, all three ports on the same index.
    write(4'd3, 32'hDEAD_BEEF);
    set_reads(4'd3, 4'd3, 4'd3);
    expect_out("wr3_y0", P_Y0, 32'hDEAD_BEEF);
    expect_out("wr3_y1", P_Y1, 32'hDEAD_BEEF);
    expect_out("wr3_y2", P_Y2, 32'hDEAD_BEEF);
    expect_out("wr3_pc_held", P_PC, 32'h0);
    sample();
    set_reads(4'd2, 4'd4, 4'd0);
    expect_out("r2_untouched", P_Y0, 32'h0);
    expect_out("r4_untouched", P_Y1, 32'h0);
    expect_out("r0_untouched", P_Y2, 32'h0);
    sample();

    // Index 0 is writable; index 14 is adjacent to the PC and must not disturb it.
    write(4'd0, 32'h0000_1234);
    write(4'd14, 32'hAAAA_5555);
    set_reads(4'd0, 4'd14, 4'd15);
    expect_out("r0_written", P_Y0, 32'h0000_1234);
    expect_out("r14_written", P_Y1, 32'hAAAA_5555);
    expect_out("pc_after_r14", P_Y2, 32'h8);
    expect_out("pc_raw_after_r14", P_PC, 32'h0);
    sample();

    // Five increments from the reset PC.
    bus.PC_INC = 1'b1;
    repeat (5) tick();
    bus.PC_INC = 1'b0;
    set_reads(4'd15, 4'd3, 4'd0);
    expect_out("inc5_pc", P_PC, 32'h14);
    expect_out("inc5_y0", P_Y0, 32'h1C);
    sample();
    tick();
    expect_out("hold_pc", P_PC, 32'h14);
    sample();

    // Write to PC beats increment on the same edge.
    bus.PC_INC = 1'b1;
    write(4'd15, 32'h0000_0100);
    bus.PC_INC = 1'b0;
    set_reads(4'd3, 4'd0, 4'd15);
    expect_out("pcwr_pc", P_PC, 32'h100);
    expect_out("pcwr_y2", P_Y2, 32'h108);
    sample();

    // Read offset and increment both wrap modulo 2**32.
    write(4'd15, 32'hFFFF_FFFC);
    set_reads(4'd15, 4'd15, 4'd15);
    expect_out("pcmax_pc", P_PC, 32'hFFFF_FFFC);
    expect_out("pcmax_y0_wrap", P_Y0, 32'h4);
    expect_out("pcmax_y1_wrap", P_Y1, 32'h4);
    sample();
    bus.PC_INC = 1'b1;
    tick();
    bus.PC_INC = 1'b0;
    expect_out("wrap_pc", P_PC, 32'h0);
    expect_out("wrap_y0", P_Y0, 32'h8);
    sample();

    // Same-cycle read of a register being written.
    bus.LE = 1'b0; bus.Rc = 4'd5; bus.I = 32'h55;
    set_reads(4'd5, 4'd6, 4'd3);
`ifdef RF_BYPASS_EN
    expect_out("bypass_y0", P_Y0, 32'h55);
`else
    expect_out("nobypass_y0", P_Y0, 32'h0);
`endif
    expect_out("bypass_other_port", P_Y1, 32'h0);
    sample();
    tick();
    bus.LE = 1'b1;
    expect_out("after_edge_y0", P_Y0, 32'h55);
    sample();

    // Asynchronous reset clears storage with no clock edge.
    write(4'd7, 32'h77);
    set_reads(4'd7, 4'd15, 4'd3);
    expect_out("r7_written", P_Y0, 32'h77);
    sample();
    clr = 1'b0;
    expect_out("async_r7", P_Y0, 32'h0);
    expect_out("async_pc_y1", P_Y1, 32'h8);
    expect_out("async_r3", P_Y2, 32'h0);
    expect_out("async_pc", P_PC, 32'h0);
    sample();

    // Writes and increments are dropped while reset is held across an edge.
    bus.LE = 1'b0; bus.Rc = 4'd3; bus.I = 32'h1111_2222; bus.PC_INC = 1'b1;
    tick();
    bus.LE = 1'b1;
    expect_out("rst_hold_r3", P_Y2, 32'h0);
    expect_out("rst_hold_pc", P_PC, 32'h0);
    sample();

    // Release mid-cycle; first increment lands on the next edge.
    clr = 1'b1;
    tick();
    bus.PC_INC = 1'b0;
    expect_out("post_rel_pc", P_PC, 32'h4);
    expect_out("post_rel_y1", P_Y1, 32'hC);
    sample();

    if (exp_q.size() != 0) begin
      tests_run++;
      tests_failed++;
      $display("FAIL scoreboard_drain: %0d expectations left, expected 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
